rom_burst_reader: RTL

//  Read sequencer placed directly upstream of the 32x8 ROM. Accepts a burst

---
 rtl/rom_burst_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rom_burst_reader.sv
// Burst read sequencer for a registered-output ROM: issues one address per cycle under
// FIFO credit, captures the returned words and streams them out with a per-beat last flag.
module rom_burst_reader #(
  parameter int ADDR    = 5,
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 6,
  parameter int DEPTH   = 4,
  parameter int ROM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ADDR-1:0]  req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             rom_rd,
  output logic [ADDR-1:0]  rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for a request; zero-length requests complete here
  // ISSUE | driving ROM reads while FIFO credit allows
  // DRAIN | all beats issued; waiting for the pipe and FIFO to empty
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = $clog2(DEPTH + ROM_LAT + 3);

  state_t             state;
  logic [ADDR-1:0]    cur_addr;
  logic [LEN_W-1:0]   remaining;
  logic [ROM_LAT:0]   pipe_v;
  logic [ROM_LAT:0]   pipe_l;

  logic [WIDTH-1:0]   mem_data [DEPTH];
  logic               mem_last [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   count_next;

  logic               push;
  logic               pop;
  logic               credit;
  logic               drained;
  logic [OCC_W-1:0]   inflight;
  logic [OCC_W-1:0]   inflight_after;
  logic [OCC_W-1:0]   occupancy;

  assign rom_rd    = pipe_v[0];
  assign push      = pipe_v[ROM_LAT];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_last  = out_valid & mem_last[rd_ptr];

  // inflight_after excludes the top stage, which lands in the FIFO this edge
  always_comb begin
    inflight       = '0;
    inflight_after = '0;
    for (int i = 0; i <= ROM_LAT; i++) inflight += OCC_W'(pipe_v[i]);
    for (int i = 0; i < ROM_LAT; i++) inflight_after += OCC_W'(pipe_v[i]);
  end

  assign occupancy  = OCC_W'(fifo_count) + inflight - OCC_W'(pop);
  assign credit     = (occupancy < OCC_W'(DEPTH));
  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign drained    = (count_next == '0) && (inflight_after == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      pipe_v    <= '0;
      pipe_l    <= '0;
      rom_addr  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      for (int i = ROM_LAT; i > 0; i--) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_l[i] <= pipe_l[i-1];
      end
      pipe_v[0] <= 1'b0;
      pipe_l[0] <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_len != '0) begin
              cur_addr  <= req_addr;
              remaining <= req_len;
              state     <= ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (credit) begin
            pipe_v[0] <= 1'b1;
            pipe_l[0] <= (remaining == LEN_W'(1));
            rom_addr  <= cur_addr;
            cur_addr  <= cur_addr + ADDR'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drained) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_next;
    end
  end

  // Storage needs no reset: entries are only visible through fifo_count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= rom_data;
      mem_last[wr_ptr] <= pipe_l[ROM_LAT];
    end
  end

endmodule
